fpu_seq: RTL and testbench



---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_result_fifo.sv | 63 ++++++
 rtl/fpu_units.sv | 133 +++++++++++++
 rtl/fpu_seq.sv | 149 ++++++++++++++
 tb/tb_fpu_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the sequenced single-precision FPU front end.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_DIV = 2'd2,
        OP_MUL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_DIV,
        S_WRITE
    } state_e;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_TMO  = 3;

    localparam logic [31:0] QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpu_result_fifo.sv
// Result queue; head entry drives the outputs and reads as zero while empty.
module fpu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && cnt_q == '0)) else $error("result fifo popped while empty");
            assert (!(push && full)) else $error("result fifo pushed while full");
        end
    end

    assign full      = (cnt_q == FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/fpu_units.sv
// Arithmetic units for normalised single-precision operands: registered adder,
// registered multiplier and a start/done divider. Results are truncated, not rounded.
module fpu_add (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        funct,
    output logic [31:0] res,
    output logic        ovf,
    output logic        unf
);
    logic              sb_eff, swap, sub, rs;
    logic [7:0]        e_big, e_sml;
    logic [25:0]       m_big, m_sml;
    logic [26:0]       sum, norm;
    logic [4:0]        lz;
    logic signed [9:0] e_new;
    logic [31:0]       res_d, res_q;
    logic              ovf_d, ovf_q, unf_d, unf_q;
    logic              unused_bits;

    always_comb begin
        sb_eff = b[31] ^ funct;
        swap   = b[30:0] > a[30:0];
        sub    = a[31] ^ sb_eff;
        rs     = swap ? sb_eff : a[31];
        e_big  = swap ? b[30:23] : a[30:23];
        e_sml  = swap ? a[30:23] : b[30:23];
        m_big  = {1'b1, (swap ? b[22:0] : a[22:0]), 2'b00};
        m_sml  = {1'b1, (swap ? a[22:0] : b[22:0]), 2'b00} >> (e_big - e_sml);
        sum    = sub ? ({1'b0, m_big} - {1'b0, m_sml}) : ({1'b0, m_big} + {1'b0, m_sml});
        // lz brings the leading one to bit 26; the hidden bit then sits at norm[26]
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        norm  = sum << lz;
        e_new = $signed({2'b00, e_big}) + 10'sd1 - $signed({5'd0, lz});
        res_d = {rs, e_new[7:0], norm[25:3]};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (sum == 27'd0) begin
            res_d = 32'd0;
        end else if (e_new >= 255) begin
            res_d = {rs, 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else if (e_new <= 0) begin
            res_d = {rs, 31'd0};
            unf_d = 1'b1;
        end
    end

    assign unused_bits = norm[26] ^ (^norm[2:0]);

    always_ff @(posedge clk) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
    end

    assign res = res_q;
    assign ovf = ovf_q;
    assign unf = unf_q;
endmodule

module fpu_mul (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res
);
    logic [47:0]       prod;
    logic signed [9:0] e_new;
    logic [22:0]       man;
    logic [31:0]       res_d, res_q;
    logic              unused_bits;

    always_comb begin
        prod  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e_new = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
              + (prod[47] ? 10'sd1 : 10'sd0);
        man   = prod[47] ? prod[46:24] : prod[45:23];
        res_d = {a[31] ^ b[31], e_new[7:0], man};
        if (e_new >= 255)    res_d = {a[31] ^ b[31], 8'hFF, 23'd0};
        else if (e_new <= 0) res_d = {a[31] ^ b[31], 31'd0};
    end

    assign unused_bits = ^prod[22:0];

    always_ff @(posedge clk) res_q <= res_d;

    assign res = res_q;
endmodule

module fpu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic        done
);
    logic [47:0]       quo;
    logic signed [9:0] e_new;
    logic [22:0]       man;
    logic [31:0]       q_d, q_q;
    logic              done_d, done_q;
    logic              unused_bits;

    always_comb begin
        // mantissa ratio lies in (0.5, 2), so the quotient's leading one is bit 24 or 23
        quo   = {1'b1, a[22:0], 24'd0} / 48'({1'b1, b[22:0]});
        e_new = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127
              - (quo[24] ? 10'sd0 : 10'sd1);
        man   = quo[24] ? quo[23:1] : quo[22:0];
        q_d   = {a[31] ^ b[31], e_new[7:0], man};
        if (e_new >= 255)    q_d = {a[31] ^ b[31], 8'hFF, 23'd0};
        else if (e_new <= 0) q_d = {a[31] ^ b[31], 31'd0};
        done_d = start;
    end

    assign unused_bits = ^quo[47:25];

    always_ff @(posedge clk) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= done_d;
        if (start) q_q <= q_d;
    end

    assign q    = q_q;
    assign done = done_q;
endmodule

// File: rtl/fpu_seq.sv
// Handshaked single-op FPU sequencer: one tagged operation in flight, results
// returned in order through a registered queue, divide bounded by a timeout.
module fpu_seq import fpu_pkg::*; #(
    parameter int TAG_W       = 4,
    parameter int OUT_DEPTH   = 2,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags,
    output logic             busy
);
    localparam int CNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam int ENT_W = 32 + TAG_W + 4;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flg_q, flg_d;
    logic [31:0]      add_res, mul_res, div_q;
    logic             add_ovf, add_unf, div_done, div_start;
    logic             fifo_push, fifo_pop, fifo_full;
    logic [ENT_W-1:0] head;

    function automatic logic [3:0] exp_flags(input logic [31:0] r);
        logic [3:0] f;
        f            = 4'd0;
        f[FLAG_ZERO] = (r[30:0] == 31'd0);
        f[FLAG_OVF]  = (r[30:23] == 8'hFF);
        f[FLAG_UNF]  = (r[30:23] == 8'h00) && (r[22:0] != 23'd0);
        return f;
    endfunction

    fpu_add u_add (.clk(clk), .a(a_q), .b(b_q), .funct(op_q == OP_SUB),
                   .res(add_res), .ovf(add_ovf), .unf(add_unf));
    fpu_mul u_mul (.clk(clk), .a(a_q), .b(b_q), .res(mul_res));
    fpu_div u_div (.clk(clk), .rst(rst), .start(div_start), .a(a_q), .b(b_q),
                   .q(div_q), .done(div_done));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        flg_d     = flg_q;
        fifo_push = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    tag_d   = tag;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_DIV) begin
                    div_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT_DIV;
                end else if (cnt_q == '0) begin
                    // adder and multiplier outputs are registered: wait one cycle
                    cnt_d = CNT_W'(1);
                end else begin
                    flg_d = 4'd0;
                    if (op_q == OP_MUL) begin
                        res_d = mul_res;
                        flg_d = exp_flags(mul_res);
                    end else begin
                        res_d            = add_res;
                        flg_d[FLAG_ZERO] = (add_res[30:0] == 31'd0);
                        flg_d[FLAG_OVF]  = add_ovf;
                        flg_d[FLAG_UNF]  = add_unf;
                    end
                    state_d = S_WRITE;
                end
            end
            S_WAIT_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (div_done) begin
                    res_d   = div_q;
                    flg_d   = exp_flags(div_q);
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    res_d           = QNAN;
                    flg_d           = 4'd0;
                    flg_d[FLAG_TMO] = 1'b1;
                    state_d         = S_WRITE;
                end
            end
            S_WRITE: begin
                fifo_push = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        tag_q <= tag_d;
        res_q <= res_d;
        flg_q <= flg_d;
    end

    fpu_result_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(ENT_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({res_q, tag_q, flg_q}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .out_valid (out_valid),
        .head      (head)
    );

    assign fifo_pop                 = out_valid && out_ready;
    assign in_ready                 = (state_q == S_IDLE) && !fifo_full;
    assign busy                     = (state_q != S_IDLE) || out_valid;
    assign {result, out_tag, flags} = head;
endmodule

// File: tb/tb_fpu_seq.sv
// Directed-vector bench for fpu_seq with hand-computed expected results.
module tb_fpu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_tag;
    logic [3:0]  flags;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int lat;

    fpu_seq #(.TAG_W(4), .OUT_DEPTH(2), .DIV_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] t);
        int n;
        op       = o;
        a        = x;
        b        = y;
        tag      = t;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("issue_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        op       = 2'd0;
        a        = 32'hDEADBEEF;
        b        = 32'hDEADBEEF;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        check("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 2'd0;
        a         = 32'd0;
        b         = 32'd0;
        tag       = 4'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1.0 + 2.0
        issue(2'd0, 32'h3F800000, 32'h40000000, 4'd5);
        check("add_in_ready_low", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("add_latency", lat, 32'd3);
        check("add_result", result, 32'h40400000);
        check("add_tag", {28'd0, out_tag}, 32'd5);
        check("add_flags", {28'd0, flags}, 32'd0);

        // 3.0 - 3.0
        issue(2'd1, 32'h40400000, 32'h40400000, 4'd3);
        wait_out(lat);
        check("sub_zero_mag", {1'b0, result[30:0]}, 32'd0);
        check("sub_zero_flags", {28'd0, flags}, 32'd1);
        check("sub_zero_tag", {28'd0, out_tag}, 32'd3);
        tick();

        // 3.0 * 2.0 then 6.0 / 2.0 queued behind a stalled consumer
        out_ready = 1'b0;
        issue(2'd3, 32'h40400000, 32'h40000000, 4'd1);
        issue(2'd2, 32'h40C00000, 32'h40000000, 4'd2);
        for (int i = 0; i < 10; i++) tick();
        check("q_out_valid", {31'd0, out_valid}, 32'd1);
        check("q_head_tag", {28'd0, out_tag}, 32'd1);
        check("q_mul_result", result, 32'h40C00000);
        check("q_mul_flags", {28'd0, flags}, 32'd0);
        check("q_busy", {31'd0, busy}, 32'd1);
        op       = 2'd0;
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        tag      = 4'd15;
        in_valid = 1'b1;
        check("q_full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("q_third_blocked", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("q_pop1_tag", {28'd0, out_tag}, 32'd2);
        check("q_div_result", result, 32'h40400000);
        check("q_div_flags", {28'd0, flags}, 32'd0);
        tick();
        check("q_drained", {31'd0, out_valid}, 32'd0);

        // overflow on multiply and on add
        issue(2'd3, 32'h7F000000, 32'h40000000, 4'd10);
        wait_out(lat);
        check("mul_ovf_result", result, 32'h7F800000);
        check("mul_ovf_flags", {28'd0, flags}, 32'd2);
        tick();
        issue(2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'd11);
        wait_out(lat);
        check("add_ovf_result", result, 32'h7F800000);
        check("add_ovf_flags", {28'd0, flags}, 32'd2);
        tick();

        // divider never finishes
        force dut.div_done = 1'b0;
        issue(2'd2, 32'h40C00000, 32'h40000000, 4'd7);
        wait_out(lat);
        release dut.div_done;
        check("tmo_latency", lat, 32'd10);
        check("tmo_result", result, 32'h7FC00000);
        check("tmo_flags", {28'd0, flags}, 32'h8);
        check("tmo_tag", {28'd0, out_tag}, 32'd7);
        tick();

        // reset while a divide is pending and a result is queued
        out_ready = 1'b0;
        issue(2'd0, 32'h3F800000, 32'h3F800000, 4'd6);
        wait_out(lat);
        force dut.div_done = 1'b0;
        issue(2'd2, 32'h40C00000, 32'h40000000, 4'd9);
        tick();
        tick();
        tick();
        check("mid_div_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        release dut.div_done;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        issue(2'd0, 32'h3F800000, 32'h40000000, 4'd4);
        wait_out(lat);
        check("post_rst_latency", lat, 32'd3);
        check("post_rst_result", result, 32'h40400000);
        check("post_rst_tag", {28'd0, out_tag}, 32'd4);
        tick();
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
